// File: rtl/fic0_apb_slot_ctrl.sv
// FIC_0 APB fan-out: decodes one of up to 16 4 KB slots, re-issues the transfer
// downstream through registered outputs, and answers timeouts/decode misses with PSLVERR.

module fic0_apb_slot_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic sel_d,
  input  logic to_set,
  input  logic to_clr,
  output logic psel,
  output logic tstat
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psel  <= 1'b0;
      tstat <= 1'b0;
    end else begin
      psel <= sel_d;
      // a timeout landing in the same cycle as a clear pulse must not be lost
      if (to_set)      tstat <= 1'b1;
      else if (to_clr) tstat <= 1'b0;
    end
  end
endmodule

module fic0_apb_slot_ctrl #(
  parameter int NUM_SLOTS      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      MCCC_CLK_BASE,
  input  logic                      MSS_RESET_N_M2F,
  input  logic [31:0]               FIC_0_APB_M_PADDR,
  input  logic                      FIC_0_APB_M_PSEL,
  input  logic                      FIC_0_APB_M_PENABLE,
  input  logic                      FIC_0_APB_M_PWRITE,
  input  logic [31:0]               FIC_0_APB_M_PWDATA,
  output logic [31:0]               FIC_0_APB_M_PRDATA,
  output logic                      FIC_0_APB_M_PREADY,
  output logic                      FIC_0_APB_M_PSLVERR,
  output logic [NUM_SLOTS-1:0]      S_PSEL,
  output logic                      S_PENABLE,
  output logic                      S_PWRITE,
  output logic [11:0]               S_PADDR,
  output logic [31:0]               S_PWDATA,
  input  logic [32*NUM_SLOTS-1:0]   S_PRDATA,
  input  logic [NUM_SLOTS-1:0]      S_PREADY,
  input  logic [NUM_SLOTS-1:0]      S_PSLVERR,
  output logic [NUM_SLOTS-1:0]      TIMEOUT_STATUS,
  input  logic [NUM_SLOTS-1:0]      TIMEOUT_CLR,
  output logic [7:0]                ERR_COUNT
);
  localparam int CW = 10;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DS_SETUP, DS_ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [11:0]     addr_d;
  logic            wr_d;
  logic [31:0]     wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pready_d, pslverr_d, penable_d, sel_en_d, to_set;
  logic [31:0]     prdata_d;
  logic            ready_sel, slverr_sel;
  logic [31:0]     rdata_sel;
  logic            unused_paddr_hi;

  assign unused_paddr_hi = ^FIC_0_APB_M_PADDR[31:16];

  // response mux for the slot captured at setup
  always_comb begin
    ready_sel  = 1'b0;
    slverr_sel = 1'b0;
    rdata_sel  = '0;
    for (int n = 0; n < NUM_SLOTS; n++) begin
      if (idx_q == 4'(n)) begin
        ready_sel  = S_PREADY[n];
        slverr_sel = S_PSLVERR[n];
        rdata_sel  = S_PRDATA[32*n +: 32];
      end
    end
  end

  // next-state and next-output values; every output is a flop loaded from here
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = S_PADDR;
    wr_d      = S_PWRITE;
    wdata_d   = S_PWDATA;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    penable_d = 1'b0;
    sel_en_d  = 1'b0;
    to_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (FIC_0_APB_M_PSEL && !FIC_0_APB_M_PENABLE) begin
          idx_d   = FIC_0_APB_M_PADDR[15:12];
          addr_d  = FIC_0_APB_M_PADDR[11:0];
          wr_d    = FIC_0_APB_M_PWRITE;
          wdata_d = FIC_0_APB_M_PWDATA;
          if ({1'b0, FIC_0_APB_M_PADDR[15:12]} < 5'(NUM_SLOTS)) begin
            state_d  = DS_SETUP;
            sel_en_d = 1'b1;
          end else begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end
        end
      end
      DS_SETUP: begin
        cnt_d     = '0;
        state_d   = DS_ACCESS;
        sel_en_d  = 1'b1;
        penable_d = 1'b1;
      end
      DS_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (ready_sel) begin
          state_d   = RESP;
          pready_d  = 1'b1;
          prdata_d  = rdata_sel;
          pslverr_d = slverr_sel;
        end else if (cnt_q == TO_LAST) begin
          state_d   = RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          to_set    = 1'b1;
        end else begin
          sel_en_d  = 1'b1;
          penable_d = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MCCC_CLK_BASE or negedge MSS_RESET_N_M2F) begin
    if (!MSS_RESET_N_M2F) begin
      state_q             <= IDLE;
      idx_q               <= '0;
      cnt_q               <= '0;
      S_PADDR             <= '0;
      S_PWRITE            <= 1'b0;
      S_PWDATA            <= '0;
      S_PENABLE           <= 1'b0;
      FIC_0_APB_M_PREADY  <= 1'b0;
      FIC_0_APB_M_PSLVERR <= 1'b0;
      FIC_0_APB_M_PRDATA  <= '0;
      ERR_COUNT           <= '0;
    end else begin
      state_q             <= state_d;
      idx_q               <= idx_d;
      cnt_q               <= cnt_d;
      S_PADDR             <= addr_d;
      S_PWRITE            <= wr_d;
      S_PWDATA            <= wdata_d;
      S_PENABLE           <= penable_d;
      FIC_0_APB_M_PREADY  <= pready_d;
      FIC_0_APB_M_PSLVERR <= pslverr_d;
      FIC_0_APB_M_PRDATA  <= prdata_d;
      // error responses are counted as RESP retires
      if (state_q == RESP && FIC_0_APB_M_PSLVERR && ERR_COUNT != 8'hFF)
        ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end

  for (genvar n = 0; n < NUM_SLOTS; n++) begin : g_lane
    fic0_apb_slot_lane u_lane (
      .clk    (MCCC_CLK_BASE),
      .rst_n  (MSS_RESET_N_M2F),
      .sel_d  (sel_en_d && (idx_d == 4'(n))),
      .to_set (to_set && (idx_q == 4'(n))),
      .to_clr (TIMEOUT_CLR[n]),
      .psel   (S_PSEL[n]),
      .tstat  (TIMEOUT_STATUS[n])
    );
  end

endmodule

// File: tb/tb_fic0_apb_slot_ctrl.sv
// Randomised bench for fic0_apb_slot_ctrl: reactive completers plus a per-transfer
// reference model of latency, response, sticky timeout flags and the error counter.

module tb_fic0_apb_slot_ctrl;
  localparam int NS = 4;
  localparam int TO = 8;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] prdata;
  logic pready, pslverr;
  logic [NS-1:0] s_psel;
  logic s_penable, s_pwrite;
  logic [11:0] s_paddr;
  logic [31:0] s_pwdata;
  logic [32*NS-1:0] s_prdata = '0;
  logic [NS-1:0] s_pready = '0, s_pslverr = '0;
  logic [NS-1:0] tstat;
  logic [NS-1:0] tclr = '0;
  logic [7:0] err_count;

  int n_tests = 0, n_fail = 0;
  int wait_cfg[NS];
  logic [31:0] rd_cfg[NS];
  bit er_cfg[NS];
  int acc[NS];
  int exp_errs = 0;
  logic [NS-1:0] exp_stat = '0;

  fic0_apb_slot_ctrl #(.NUM_SLOTS(NS), .TIMEOUT_CYCLES(TO)) dut (
    .MCCC_CLK_BASE(gclk), .MSS_RESET_N_M2F(grst_n),
    .FIC_0_APB_M_PADDR(paddr), .FIC_0_APB_M_PSEL(psel), .FIC_0_APB_M_PENABLE(penable),
    .FIC_0_APB_M_PWRITE(pwrite), .FIC_0_APB_M_PWDATA(pwdata),
    .FIC_0_APB_M_PRDATA(prdata), .FIC_0_APB_M_PREADY(pready), .FIC_0_APB_M_PSLVERR(pslverr),
    .S_PSEL(s_psel), .S_PENABLE(s_penable), .S_PWRITE(s_pwrite), .S_PADDR(s_paddr),
    .S_PWDATA(s_pwdata), .S_PRDATA(s_prdata), .S_PREADY(s_pready), .S_PSLVERR(s_pslverr),
    .TIMEOUT_STATUS(tstat), .TIMEOUT_CLR(tclr), .ERR_COUNT(err_count)
  );

  always #5 gclk = ~gclk;

  // each completer goes ready after wait_cfg[s] stalled access cycles (-1: never)
  always @(negedge gclk) begin
    for (int s = 0; s < NS; s++) begin
      if (s_psel[s] && s_penable) acc[s] = acc[s] + 1;
      else acc[s] = 0;
      s_pready[s] = (wait_cfg[s] >= 0) && (acc[s] > wait_cfg[s]);
      s_pslverr[s] = er_cfg[s];
      s_prdata[32*s +: 32] = rd_cfg[s];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clr_pulse(input logic [NS-1:0] mask);
    tclr = mask;
    @(negedge gclk);
    tclr = '0;
    exp_stat = exp_stat & ~mask;
    chk("clr_stat", 32'(tstat), 32'(exp_stat));
  endtask

  // called on a negedge with the DUT idle; returns on a negedge with the DUT idle
  task automatic xfer(input int slot, input logic [11:0] off, input bit wr,
                      input logic [31:0] wdata, input int wt, input logic [31:0] rd,
                      input bit er, input int clr_cyc, input logic [NS-1:0] clr_mask,
                      input bit drop);
    logic [31:0] hi, prd, pw1;
    logic perr, pwr1;
    logic [11:0] pa1;
    logic [NS-1:0] psel1, psel_r, bitm;
    int cyc, pen, lat, e_lat, e_pen;
    bit got, valid, tmo, e_err, clr_hit;
    hi = $urandom;
    valid = slot < NS;
    bitm = '0;
    if (valid) begin
      bitm[slot] = 1'b1;
      wait_cfg[slot] = wt; rd_cfg[slot] = rd; er_cfg[slot] = er;
    end
    paddr = {hi[31:16], 4'(slot), off};
    pwrite = wr; pwdata = wdata; psel = 1'b1; penable = 1'b0;
    cyc = 0; pen = 0; got = 0; lat = -1; prd = '0; perr = 1'b0;
    psel1 = '0; psel_r = '1; pa1 = '0; pw1 = '0; pwr1 = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge gclk);
      cyc++;
      if (cyc == 1) begin
        penable = 1'b1;
        psel1 = s_psel; pa1 = s_paddr; pw1 = s_pwdata; pwr1 = s_pwrite;
      end
      if (drop && cyc == 2) begin psel = 1'b0; penable = 1'b0; end
      tclr = (cyc == clr_cyc) ? clr_mask : '0;
      if (s_penable) pen++;
      if (pready) begin
        got = 1; lat = cyc; prd = prdata; perr = pslverr; psel_r = s_psel;
      end
    end
    psel = 1'b0; penable = 1'b0; tclr = '0;

    tmo   = valid && (wt < 0 || wt >= TO);
    e_lat = !valid ? 1 : (tmo ? TO + 2 : wt + 3);
    e_pen = !valid ? 0 : (tmo ? TO : wt + 1);
    e_err = !valid || tmo || er;
    chk("latency", 32'(lat), 32'(e_lat));
    chk("prdata", prd, (!valid || tmo) ? 32'h0 : rd);
    chk("pslverr", 32'(perr), 32'(e_err));
    chk("penable_cycles", 32'(pen), 32'(e_pen));
    chk("psel_setup", 32'(psel1), 32'(bitm));
    chk("psel_resp", 32'(psel_r), 32'h0);
    if (valid) begin
      chk("s_paddr", 32'(pa1), 32'(off));
      chk("s_pwdata", pw1, wdata);
      chk("s_pwrite", 32'(pwr1), 32'(wr));
    end

    // timeout flag is set at the end of access cycle TO+1; a clear after that wins
    clr_hit = clr_cyc >= 1 && clr_cyc <= e_lat;
    if (tmo && clr_hit && clr_cyc > TO + 1) exp_stat = (exp_stat | bitm) & ~clr_mask;
    else begin
      if (clr_hit) exp_stat = exp_stat & ~clr_mask;
      if (tmo) exp_stat = exp_stat | bitm;
    end
    if (e_err && exp_errs < 255) exp_errs++;

    @(negedge gclk);
    chk("err_count", 32'(err_count), 32'(exp_errs));
    chk("tstat", 32'(tstat), 32'(exp_stat));
  endtask

  initial begin
    int slot, r, cc;
    logic [31:0] v1, v2;
    for (int s = 0; s < NS; s++) begin
      wait_cfg[s] = 0; rd_cfg[s] = '0; er_cfg[s] = 0; acc[s] = 0;
    end
    repeat (3) @(negedge gclk);
    chk("reset_outputs", 32'(|{prdata, pready, pslverr, s_psel, s_penable, s_pwrite,
                                s_paddr, s_pwdata, tstat, err_count}), 32'h0);
    grst_n = 1'b1;
    @(negedge gclk);

    xfer(1, 12'h010, 1, 32'h12345678, 0, 32'h0, 0, 0, '0, 0);
    xfer(3, 12'h0a4, 0, 32'h0, 5, 32'hCAFEF00D, 1, 0, '0, 0);
    xfer(4, 12'h000, 0, 32'h0, 0, 32'h0, 0, 0, '0, 0);
    xfer(2, 12'h100, 0, 32'h0, -1, 32'h0, 0, 0, '0, 0);
    clr_pulse(4'b0100);
    xfer(0, 12'h3fc, 0, 32'h0, TO - 1, 32'h5a5a1234, 0, 0, '0, 0);
    // clear pulse coincident with the timeout on the same slot
    xfer(2, 12'h008, 1, 32'hdeadbeef, -1, 32'h0, 0, TO + 1, 4'b0100, 0);
    clr_pulse(4'b0100);
    // upstream drops PSEL mid-transfer; downstream still completes
    xfer(1, 12'h020, 0, 32'h0, 2, 32'h0badf00d, 0, 0, '0, 1);

    for (int i = 0; i < 60; i++) begin
      slot = $urandom_range(0, 5);
      r = $urandom_range(0, 12);
      cc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO + 2) : 0;
      v1 = $urandom; v2 = $urandom;
      xfer(slot, v1[11:0], v1[12], v2, (r == 12) ? -1 : r, $urandom, v1[13],
           cc, v1[19:16], v1[20]);
    end

    for (int i = 0; i < 256; i++) begin
      slot = $urandom_range(NS, 15);
      xfer(slot, 12'h0, 0, 32'h0, 0, 32'h0, 0, 0, '0, 0);
    end
    chk("err_sat", 32'(err_count), 32'd255);

    xfer(3, 12'h0, 0, 32'h0, -1, 32'h0, 0, 0, '0, 0);

    // reset during DS_ACCESS of a slot-0 read
    wait_cfg[0] = -1;
    paddr = 32'h4000_0000; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge gclk); penable = 1'b1;
    @(negedge gclk);
    chk("pre_reset_penable", 32'(s_penable), 32'h1);
    grst_n = 1'b0;
    #1;
    chk("rst_err_count", 32'(err_count), 32'h0);
    chk("rst_tstat", 32'(tstat), 32'h0);
    chk("rst_all_outputs", 32'(|{prdata, pready, pslverr, s_psel, s_penable, s_pwrite,
                                  s_paddr, s_pwdata, tstat, err_count}), 32'h0);
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(negedge gclk);
    grst_n = 1'b1;
    exp_errs = 0; exp_stat = '0;
    @(negedge gclk);
    xfer(0, 12'h004, 0, 32'h0, 1, 32'h600dcafe, 0, 0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fic0_apb_slot_ctrl.md
# fic0_apb_slot_ctrl

Fabric-side APB controller that sits behind the MSS FIC_0 APB master port and shares it among up to 16 fabric APB completers, one 4 KB slot per completer. Each upstream transfer is decoded, re-issued to the selected completer as a registered downstream APB transfer, and guarded by a per-transfer timeout. Timeouts and decode misses are answered upstream with PSLVERR, so a hung or absent peripheral never stalls the Cortex-M3.

## Interface
Parameters:
- NUM_SLOTS, 4: number of downstream completers, legal range 1..16.
- TIMEOUT_CYCLES, 255: maximum downstream access-phase cycles, legal range 2..1023.

Ports (reset is asynchronous, active-low; one clock):
- MCCC_CLK_BASE  in  1  fabric clock, shared with the MSS FIC_0 interface.
- MSS_RESET_N_M2F  in  1  asynchronous active-low reset.
- FIC_0_APB_M_PADDR  in  32  upstream address.
- FIC_0_APB_M_PSEL, FIC_0_APB_M_PENABLE, FIC_0_APB_M_PWRITE  in  1  upstream controls.
- FIC_0_APB_M_PWDATA  in  32  upstream write data.
- FIC_0_APB_M_PRDATA  out  32  upstream read data.
- FIC_0_APB_M_PREADY, FIC_0_APB_M_PSLVERR  out  1  upstream response.
- S_PSEL  out  NUM_SLOTS  one-hot downstream select.
- S_PENABLE, S_PWRITE  out  1  downstream controls.
- S_PADDR  out  12  downstream offset, PADDR[11:0].
- S_PWDATA  out  32  downstream write data.
- S_PRDATA  in  32*NUM_SLOTS  read data; slot n occupies bits [32n+31:32n].
- S_PREADY, S_PSLVERR  in  NUM_SLOTS  per-slot response.
- TIMEOUT_STATUS  out  NUM_SLOTS  sticky per-slot timeout flags.
- TIMEOUT_CLR  in  NUM_SLOTS  one-cycle pulse; clears the matching flags.
- ERR_COUNT  out  8  saturating count of upstream PSLVERR responses.

## Operation
- Slot index = PADDR[15:12]. PADDR[31:16] is ignored (the FIC_0 window decode is done upstream).
- FSM states: IDLE, DS_SETUP, DS_ACCESS, RESP.
- IDLE:
  - On PSEL=1 and PENABLE=0, capture PADDR, PWRITE, PWDATA and the slot index.
  - If index < NUM_SLOTS, go to DS_SETUP. Otherwise go to RESP with error=1 and rdata=0.
- DS_SETUP:
  - S_PSEL[idx]=1, S_PENABLE=0; all downstream outputs are driven from registers.
  - Clear the timeout counter. Go to DS_ACCESS.
- DS_ACCESS:
  - S_PSEL[idx]=1, S_PENABLE=1. The counter increments each cycle.
  - If S_PREADY[idx]=1: capture S_PRDATA slice into rdata and S_PSLVERR[idx] into error; go to RESP.
  - Else if the counter reaches TIMEOUT_CYCLES-1: error=1, rdata=0, set TIMEOUT_STATUS[idx]; go to RESP.
- RESP:
  - FIC_0_APB_M_PREADY=1 for exactly one cycle, with PRDATA=rdata and PSLVERR=error.
  - Downstream is idle: S_PSEL=0, S_PENABLE=0.
  - If error=1, ERR_COUNT increments, saturating at 255.
  - Go to IDLE.
- FIC_0_APB_M_PREADY=0 in every state except RESP. PRDATA and PSLVERR are 0 outside RESP.
- S_PADDR, S_PWRITE and S_PWDATA hold their captured values until the next capture.
- Boundary rules:
  - S_PREADY and timeout in the same cycle: S_PREADY wins (normal completion, no flag set).
  - TIMEOUT_CLR and a new timeout on the same slot in the same cycle: set wins.
  - Upstream PSEL deasserted mid-transfer (protocol violation): ignored; the downstream transfer completes and RESP still occurs.
  - A new upstream SETUP is only sampled in IDLE.
  - Reset asserted mid-transfer: the FSM returns to IDLE immediately and all outputs go to 0, including TIMEOUT_STATUS and ERR_COUNT. Downstream PSEL drops without completion.

## Timing
- All outputs are registered; no combinational path from input to output.
- Reset value of every output is 0.
- Valid slot, S_PREADY high on the first access cycle:
  - Cycle 0: upstream SETUP.
  - Cycle 1: DS_SETUP.
  - Cycle 2: DS_ACCESS, completer ready.
  - Cycle 3: RESP, upstream PREADY=1.
  - Result: 2 upstream wait states.
- Each completer wait cycle adds one upstream wait state.
- Invalid slot: upstream PREADY=1 in cycle 1 with PSLVERR=1 (zero wait states).
- Timeout: DS_ACCESS lasts exactly TIMEOUT_CYCLES cycles; upstream PREADY is at cycle TIMEOUT_CYCLES+2.
- Back-to-back transfers: next upstream SETUP no earlier than the cycle after RESP. IDLE accepts it directly.

## Test plan
- Write 0x12345678 to 0x40001010 (slot 1) with the completer ready immediately.
  - Required: S_PSEL=4'b0010 in cycles 1-2, S_PENABLE in cycle 2, S_PADDR=0x010, S_PWDATA=0x12345678.
  - Upstream PREADY in cycle 3 with PSLVERR=0.
- Read slot 3; completer waits 5 cycles, then returns 0xCAFEF00D with PSLVERR=1.
  - Required: upstream PRDATA=0xCAFEF00D and PSLVERR=1 in cycle 8; ERR_COUNT increments 0 to 1.
- Access 0x40004000 with NUM_SLOTS=4 (slot 4 does not exist).
  - Required: S_PSEL stays 0; upstream PREADY and PSLVERR=1 in cycle 1; PRDATA=0.
- Slot 2 never ready, TIMEOUT_CYCLES=8.
  - Required: S_PENABLE high for exactly 8 cycles; upstream PSLVERR=1 at cycle 10; TIMEOUT_STATUS=4'b0100.
  - A TIMEOUT_CLR=4'b0100 pulse then clears it.
- S_PREADY on the final timeout cycle: normal completion, TIMEOUT_STATUS unchanged.
  - Then 256 invalid-slot accesses: ERR_COUNT saturates at 255.
- Assert MSS_RESET_N_M2F during DS_ACCESS of a slot-0 read.
  - Required: all outputs 0 immediately.
  - After release, a new slot-0 read completes normally.
